// File: rtl/seg_pkg.sv
// Shared definitions for the segment pattern sequencer: mode encodings,
// one-hot segment constants and per-mode pattern lengths.
package seg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic [1:0] {
        MODE_FIG8  = 2'd0,
        MODE_RING  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_e;

    localparam logic [SEG_W-1:0] SEG_A    = 7'h01;
    localparam logic [SEG_W-1:0] SEG_B    = 7'h02;
    localparam logic [SEG_W-1:0] SEG_C    = 7'h04;
    localparam logic [SEG_W-1:0] SEG_D    = 7'h08;
    localparam logic [SEG_W-1:0] SEG_E    = 7'h10;
    localparam logic [SEG_W-1:0] SEG_F    = 7'h20;
    localparam logic [SEG_W-1:0] SEG_G    = 7'h40;
    localparam logic [SEG_W-1:0] SEG_ALL  = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_NONE = 7'h00;

    localparam logic [LEN_W-1:0] LEN_FIG8  = 4'd8;
    localparam logic [LEN_W-1:0] LEN_RING  = 4'd6;
    localparam logic [LEN_W-1:0] LEN_BLINK = 4'd2;
    localparam logic [LEN_W-1:0] LEN_OFF   = 4'd1;

endpackage

// File: rtl/seg_pattern_rom.sv
// Combinational pattern lookup: segment drive and pattern length for (mode, step).
module seg_pattern_rom
    import seg_pkg::*;
(
    input  mode_e                   mode_i,
    input  logic [STEP_W-1:0]       step_i,
    output logic [SEG_W-1:0]        segment_o,
    output logic [LEN_W-1:0]        len_o
);

    always_comb begin
        segment_o = SEG_NONE;
        len_o     = LEN_OFF;
        case (mode_i)
            MODE_FIG8: begin
                len_o = LEN_FIG8;
                case (step_i)
                    3'd0:    segment_o = SEG_F;
                    3'd1:    segment_o = SEG_G;
                    3'd2:    segment_o = SEG_C;
                    3'd3:    segment_o = SEG_D;
                    3'd4:    segment_o = SEG_E;
                    3'd5:    segment_o = SEG_G;
                    3'd6:    segment_o = SEG_B;
                    default: segment_o = SEG_A;
                endcase
            end
            MODE_RING: begin
                len_o = LEN_RING;
                case (step_i)
                    3'd0:    segment_o = SEG_A;
                    3'd1:    segment_o = SEG_B;
                    3'd2:    segment_o = SEG_C;
                    3'd3:    segment_o = SEG_D;
                    3'd4:    segment_o = SEG_E;
                    3'd5:    segment_o = SEG_F;
                    default: segment_o = SEG_NONE;
                endcase
            end
            MODE_BLINK: begin
                len_o     = LEN_BLINK;
                segment_o = (step_i == '0) ? SEG_ALL : SEG_NONE;
            end
            default: begin
                len_o     = LEN_OFF;
                segment_o = SEG_NONE;
            end
        endcase
    end

endmodule

// File: rtl/seg_pattern_seq.sv
// Seven-segment pattern sequencer: prescaled step counter walking a per-mode
// pattern table forward or backward, with registered segment drive and wrap pulse.
module seg_pattern_seq
    import seg_pkg::*;
#(
    parameter int unsigned DIV_W = 24
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [1:0]         i_mode,
    input  logic               i_reverse,
    input  logic [DIV_W-1:0]   i_div,
    output logic [SEG_W-1:0]   o_segment,
    output logic [STEP_W-1:0]  o_step,
    output logic               o_wrap
);

    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [STEP_W-1:0] step_q,  step_d;
    mode_e             mode_q,  mode_d;
    logic [SEG_W-1:0]  seg_q;
    logic              wrap_q,  wrap_d;

    logic [SEG_W-1:0]  rom_seg;
    logic [LEN_W-1:0]  rom_len;
    logic [STEP_W-1:0] last_step;

    seg_pattern_rom u_rom (
        .mode_i    (mode_q),
        .step_i    (step_q),
        .segment_o (rom_seg),
        .len_o     (rom_len)
    );

    assign last_step = STEP_W'(rom_len - LEN_W'(1));

    // A mode change restarts the pattern and wins over any tick in the same clock.
    always_comb begin
        mode_d  = mode_e'(i_mode);
        presc_d = presc_q;
        step_d  = step_q;
        wrap_d  = 1'b0;
        if (mode_d != mode_q) begin
            presc_d = '0;
            step_d  = '0;
        end else if (i_en && (mode_q != MODE_OFF)) begin
            if (presc_q >= i_div) begin
                presc_d = '0;
                if (i_reverse) begin
                    step_d = (step_q == '0) ? last_step : step_q - STEP_W'(1);
                    wrap_d = (step_q == '0);
                end else begin
                    step_d = (step_q == last_step) ? '0 : step_q + STEP_W'(1);
                    wrap_d = (step_q == last_step);
                end
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_q <= '0;
            step_q  <= '0;
            mode_q  <= MODE_FIG8;
            seg_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            seg_q   <= rom_seg;
            wrap_q  <= wrap_d;
        end
    end

    assign o_segment = seg_q;
    assign o_step    = step_q;
    assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_seg_pattern_seq.sv
// Self-checking bench for seg_pattern_seq: directed scenarios plus random
// stimulus against a table-driven reference model.
module tb_seg_pattern_seq;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       rev;
    logic [3:0] div;
    logic [6:0] seg;
    logic [2:0] step;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    int         m_mode;
    int         m_step;
    int         m_presc;
    logic [6:0] m_seg;
    logic       m_wrap;

    logic [6:0] fig8_t [8] = '{7'h20, 7'h40, 7'h04, 7'h08, 7'h10, 7'h40, 7'h02, 7'h01};
    logic [6:0] ring_t [6] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20};

    seg_pattern_seq #(.DIV_W(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_mode    (mode),
        .i_reverse (rev),
        .i_div     (div),
        .o_segment (seg),
        .o_step    (step),
        .o_wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int len_of(int m);
        case (m)
            0:       return 8;
            1:       return 6;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [6:0] tbl(int m, int s);
        case (m)
            0:       return fig8_t[s];
            1:       return ring_t[s];
            2:       return (s == 0) ? 7'h7F : 7'h00;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_presc = 0; m_seg = 7'h00; m_wrap = 1'b0;
    endtask

    // Advance the reference by one clock using the inputs present before the edge.
    task automatic model_clk();
        logic [6:0] sn;
        int len, nxt;
        sn     = tbl(m_mode, m_step);
        len    = len_of(m_mode);
        m_wrap = 1'b0;
        if (int'(mode) != m_mode) begin
            m_step = 0; m_presc = 0;
        end else if (en && m_mode != 3) begin
            if (m_presc >= int'(div)) begin
                m_presc = 0;
                nxt     = rev ? (m_step + len - 1) % len : (m_step + 1) % len;
                m_wrap  = rev ? (nxt == len - 1) : (nxt == 0);
                m_step  = nxt;
            end else begin
                m_presc++;
            end
        end
        m_mode = int'(mode);
        m_seg  = sn;
    endtask

    task automatic cyc();
        model_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'd0; en = 1'b1; rev = 1'b0; div = 4'd2;
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({step, seg, wrap} !== 11'd0)
            begin errors++; $display("FAIL reset_hold step=%0d seg=%h wrap=%b expected all zero", step, seg, wrap); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        checks++;
        if (seg !== 7'h20 || step !== 3'd0)
            begin errors++; $display("FAIL reset_release seg=%h step=%0d expected seg=20 step=0", seg, step); end
    endtask

    task automatic test_fig8_forward();
        int wraps = 0;
        int first_change = -1;
        logic [2:0] prev;
        mode = 2'd0; div = 4'd2; en = 1'b1; rev = 1'b0;
        apply_reset();
        prev = step;
        for (int c = 1; c <= 48; c++) begin
            cyc();
            checks++;
            if ({step, seg, wrap} !== {3'(m_step), m_seg, m_wrap})
                begin errors++; $display("FAIL fig8_model c=%0d step=%0d seg=%h wrap=%b expected %0d %h %b", c, step, seg, wrap, m_step, m_seg, m_wrap); end
            checks++;
            if (seg !== fig8_t[prev])
                begin errors++; $display("FAIL fig8_seg c=%0d seg=%h expected %h", c, seg, fig8_t[prev]); end
            if (wrap) wraps++;
            if (first_change < 0 && step != prev) first_change = c;
            prev = step;
        end
        checks++;
        if (wraps !== 2) begin errors++; $display("FAIL fig8_wraps got=%0d expected 2", wraps); end
        checks++;
        if (first_change !== 3) begin errors++; $display("FAIL fig8_first_step got=%0d expected 3", first_change); end
    endtask

    task automatic test_reverse_ring();
        int exp_s [7] = '{0, 5, 4, 3, 2, 1, 0};
        mode = 2'd1; rev = 1'b1; div = 4'd0; en = 1'b1;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++;
            if (step !== 3'(exp_s[i]) || wrap !== (i == 1))
                begin errors++; $display("FAIL ring_rev i=%0d step=%0d wrap=%b expected step=%0d wrap=%b", i, step, wrap, exp_s[i], (i == 1)); end
            checks++;
            if ({step, seg, wrap} !== {3'(m_step), m_seg, m_wrap})
                begin errors++; $display("FAIL ring_model i=%0d step=%0d seg=%h wrap=%b expected %0d %h %b", i, step, seg, wrap, m_step, m_seg, m_wrap); end
        end
    endtask

    task automatic test_mode_switch();
        int n = 0;
        mode = 2'd0; div = 4'd2; rev = 1'b0; en = 1'b1;
        apply_reset();
        while (step != 3'd5 && n < 40) begin cyc(); n++; end
        checks++;
        if (step !== 3'd5) begin errors++; $display("FAIL switch_reach step=%0d expected 5", step); end
        mode = 2'd2;
        cyc();
        checks++;
        if (step !== 3'd0 || wrap !== 1'b0)
            begin errors++; $display("FAIL switch_clear step=%0d wrap=%b expected 0 0", step, wrap); end
        cyc();
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL switch_blink_on seg=%h expected 7f", seg); end
        repeat (3) cyc();
        checks++;
        if (seg !== 7'h00) begin errors++; $display("FAIL switch_blink_off seg=%h expected 00", seg); end
        checks++;
        if ({step, seg, wrap} !== {3'(m_step), m_seg, m_wrap})
            begin errors++; $display("FAIL switch_model step=%0d seg=%h wrap=%b expected %0d %h %b", step, seg, wrap, m_step, m_seg, m_wrap); end
    endtask

    task automatic test_enable_gating();
        int n = 0;
        mode = 2'd0; div = 4'd2; rev = 1'b0; en = 1'b1;
        apply_reset();
        while (step != 3'd3 && n < 40) begin cyc(); n++; end
        cyc();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (step !== 3'd3 || seg !== 7'h08 || wrap !== 1'b0)
                begin errors++; $display("FAIL en_hold i=%0d step=%0d seg=%h expected step=3 seg=08", i, step, seg); end
        end
        en = 1'b1;
        cyc();
        checks++;
        if (step !== 3'd3) begin errors++; $display("FAIL en_resume1 step=%0d expected 3", step); end
        cyc();
        checks++;
        if (step !== 3'd4) begin errors++; $display("FAIL en_resume2 step=%0d expected 4", step); end
    endtask

    task automatic test_div_shrink();
        int n = 0;
        logic [2:0] s0, s1;
        mode = 2'd1; div = 4'd12; rev = 1'b0; en = 1'b1;
        apply_reset();
        while (m_presc != 9 && n < 40) begin cyc(); n++; end
        s0  = step;
        div = 4'd4;
        cyc();
        checks++;
        if (step !== 3'((int'(s0) + 1) % 6))
            begin errors++; $display("FAIL shrink_tick step=%0d expected %0d", step, (int'(s0) + 1) % 6); end
        s1 = step;
        repeat (4) cyc();
        checks++;
        if (step !== s1) begin errors++; $display("FAIL shrink_hold step=%0d expected %0d", step, s1); end
        cyc();
        checks++;
        if (step !== 3'((int'(s1) + 1) % 6))
            begin errors++; $display("FAIL shrink_period step=%0d expected %0d", step, (int'(s1) + 1) % 6); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        mode = 2'd0; div = 4'd1; rev = 1'b0; en = 1'b1;
        apply_reset();
        while (step != 3'd6 && n < 40) begin cyc(); n++; end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({step, seg, wrap} !== 11'd0)
            begin errors++; $display("FAIL async_rst step=%0d seg=%h wrap=%b expected all zero", step, seg, wrap); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        checks++;
        if (seg !== 7'h20 || step !== 3'd0)
            begin errors++; $display("FAIL async_release seg=%h step=%0d expected 20 0", seg, step); end
    endtask

    task automatic test_random();
        mode = 2'd0; div = 4'd1; rev = 1'b0; en = 1'b1;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) rev  = ~rev;
            if ($urandom_range(0, 24) == 0) div  = 4'($urandom_range(0, 5));
            en = ($urandom_range(0, 9) != 0);
            cyc();
            checks++;
            if ({step, seg, wrap} !== {3'(m_step), m_seg, m_wrap})
                begin errors++; $display("FAIL random i=%0d step=%0d seg=%h wrap=%b expected %0d %h %b", i, step, seg, wrap, m_step, m_seg, m_wrap); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; rev = 1'b0; div = 4'd0;
        model_reset();
        test_reset();
        test_fig8_forward();
        test_reverse_ring();
        test_mode_switch();
        test_enable_gating();
        test_div_shrink();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_pattern_seq.md
SEG_PATTERN_SEQ -- requirements
Module: seg_pattern_seq

Interface
REQ-001 Parameter DIV_W, default 24, SHALL set the width of the step-period prescaler and of i_div.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 i_en  input  1  run enable; low SHALL freeze the prescaler and the step.
REQ-005 i_mode  input  2  pattern select: 0 figure-8, 1 outer ring, 2 blink, 3 off.
REQ-006 i_reverse  input  1  traversal direction: 0 forward, 1 backward.
REQ-007 i_div  input  DIV_W  step period, in clocks, minus one.
REQ-008 o_segment  output  7  segment drive; bit0=a, bit1=b, ... bit6=g; 1 means lit.
REQ-009 o_step  output  3  current step index.
REQ-010 o_wrap  output  1  one-cycle pulse when the step index wraps.

Function
REQ-011 Pattern tables SHALL be as follows, indexed by step:
- Figure-8 (length 8): f,g,c,d,e,g,b,a.
- Outer ring (length 6): a,b,c,d,e,f.
- Blink (length 2): 7'h7F, 7'h00.
- Off (length 1): 7'h00.
REQ-012 The prescaler SHALL count up by one per clock while i_en=1 and mode_q!=3.
REQ-013 When the prescaler is >= i_div, a tick SHALL occur: the prescaler returns to 0 on that clock, so i_div=N gives one step per N+1 clocks.
REQ-014 On a tick with i_reverse=0, step SHALL advance: step==len-1 ? 0 : step+1.
REQ-015 On a tick with i_reverse=1, step SHALL retreat: step==0 ? len-1 : step-1.
REQ-016 o_wrap SHALL be 1 for exactly the clock in which o_step presents the wrapped value (0 when forward, len-1 when reverse), and 0 otherwise.
REQ-017 The registered copy mode_q SHALL sample i_mode every clock.
REQ-018 When i_mode != mode_q, step and prescaler SHALL clear to 0 on that clock, with no tick and no o_wrap.
REQ-019 A mode change SHALL take priority over a simultaneous tick.
REQ-020 o_step SHALL equal the step register.
REQ-021 o_segment SHALL be registered as table(mode_q, step), giving one clock of latency after any step or mode change.
REQ-022 A change on i_reverse SHALL take effect at the next tick without restarting the step.
REQ-023 A change on i_div SHALL take effect immediately; a prescaler already above the new value SHALL tick on the next enabled clock.
REQ-024 With i_en=0, o_segment and o_step SHALL hold their values; a mode change SHALL still restart the step per REQ-018.
REQ-025 In mode 3, o_segment SHALL be 0, o_step SHALL be 0 and o_wrap SHALL never assert.
REQ-026 i_div=0 SHALL step every enabled clock.

Reset
REQ-027 While i_rst=1, the following SHALL be held at 0 regardless of the clock: prescaler, step, mode_q, o_segment, o_wrap.
REQ-028 Reset asserted mid-sequence SHALL discard progress; no output glitch other than the transition to 0 is allowed.
REQ-029 On the first clock after reset release, o_segment SHALL be loaded with table(mode_q, 0).

Structure
REQ-030 Shared package seg_pkg SHALL hold:
- the mode encodings;
- one-hot segment constants SEG_A..SEG_G;
- the per-mode pattern lengths.
REQ-031 Pattern lookup SHALL be a combinational sub-module seg_pattern_rom with inputs (mode, step) and outputs (segment, len).
REQ-032 The prescaler, step register and output registers SHALL reside in seg_pattern_seq.

Verification
All scenarios use DIV_W=4.
REQ-033 Forward figure-8: mode 0, i_div=2, i_en=1 -> o_step advances every 3 clocks through 0..7, and o_segment shows 20,40,04,08,10,40,02,01 hex. o_wrap pulses once per 24 clocks, coincident with o_step returning to 0.
REQ-034 Reverse ring: mode 1, i_reverse=1, i_div=0 -> o_step runs 0,5,4,3,2,1,0, and o_wrap asserts with o_step=5.
REQ-035 Mode switch mid-run: at figure-8 step 5, i_mode changes to 2 -> the next clock gives o_step=0 with no wrap, o_segment=7F one clock later, and 00 after i_div+1 further clocks.
REQ-036 Enable gating: i_en deasserted for 10 clocks at step 3 -> o_step=3 and o_segment are held throughout; on resume, the step advances after the remaining prescaler count.
REQ-037 Divisor shrink: with the prescaler at 9, i_div changes 12->4 -> a tick occurs on the next clock and subsequent steps occur every 5 clocks.
REQ-038 Asynchronous reset mid-run at step 6: o_segment=00 and o_step=0 appear before the next clock edge, and step 0 of mode_q is shown one clock after release.
